// File: rtl/pipe_ctrl_if.sv
// Hazard/control bundle between the RV64 pipeline stages and pipe_ctrl.
// master: pipeline side (drives hazard info, receives controls).
// slave : pipe_ctrl side.
interface pipe_ctrl_if;
  logic        d_valid;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_use_rs1;
  logic        d_use_rs2;
  logic        e_valid;
  logic [4:0]  e_dst;
  logic        e_ismem;
  logic        e_branch;
  logic [63:0] e_target;
  logic [1:0]  e_mdu_op;
  logic        i_stall;
  logic        m_stall;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        bubble_e;
  logic        flush_fd;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mdu_done;
  logic [1:0]  state_o;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
    output e_valid, e_dst, e_ismem, e_branch, e_target, e_mdu_op,
    output i_stall, m_stall,
    input  stall_f, stall_d, stall_e, bubble_e, flush_fd,
    input  redirect_valid, redirect_pc, mdu_done, state_o
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
    input  e_valid, e_dst, e_ismem, e_branch, e_target, e_mdu_op,
    input  i_stall, m_stall,
    output stall_f, stall_d, stall_e, bubble_e, flush_fd,
    output redirect_valid, redirect_pc, mdu_done, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect sequencer for the 5-stage RV64 pipeline.
// Owns the MUL/DIV occupancy counter and the pending fetch redirect.
// Optional macro PIPE_CTRL_PERF_EN adds 32-bit stall/load-use/redirect
// performance counters.
module pipe_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 65,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_loaduse,
  output logic [31:0] perf_redirect
`endif
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] MDU   = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  // Counter is loaded with LAT-2: the accepting RUN cycle and the final
  // done cycle are both part of the op's occupancy of execute.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      tgt_q, tgt_d;

  logic        stall_f, stall_d, stall_e, bubble_e, flush_fd;
  logic        redirect_valid, mdu_done, lu_bubble;
  logic [63:0] redirect_pc;
  logic        load_use, is_mdu;

  assign load_use = bus.d_valid & bus.e_valid & bus.e_ismem & (bus.e_dst != 5'd0) &
                    ((bus.d_use_rs1 & (bus.d_rs1 == bus.e_dst)) |
                     (bus.d_use_rs2 & (bus.d_rs2 == bus.e_dst)));
  assign is_mdu   = bus.e_valid & ((bus.e_mdu_op == 2'b01) | (bus.e_mdu_op == 2'b10));

  // Next-state and control decode; outputs are forced low while reset is held.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tgt_d          = tgt_q;
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    bubble_e       = 1'b0;
    flush_fd       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    mdu_done       = 1'b0;
    lu_bubble      = 1'b0;
    case (state_q)
      MDU: begin
        if (cnt_q != '0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          mdu_done = 1'b1;
          stall_f  = bus.m_stall;
          stall_d  = bus.m_stall;
          stall_e  = bus.m_stall;
          if (!bus.m_stall) state_d = RUN;
        end
      end
      REDIR: begin
        // The redirect was already accepted, so a memory stall holds the
        // stages but does not block delivering it to fetch.
        flush_fd       = 1'b1;
        bubble_e       = 1'b1;
        redirect_pc    = tgt_q;
        redirect_valid = !bus.i_stall;
        stall_f        = bus.m_stall;
        stall_d        = bus.m_stall;
        stall_e        = bus.m_stall;
        if (!bus.i_stall) state_d = RUN;
      end
      default: begin
        if (bus.m_stall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end else if (bus.e_valid & bus.e_branch) begin
          flush_fd = 1'b1;
          bubble_e = 1'b1;
          if (!bus.i_stall) begin
            redirect_valid = 1'b1;
            redirect_pc    = bus.e_target;
          end else begin
            tgt_d   = bus.e_target;
            state_d = REDIR;
          end
        end else if (is_mdu) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          cnt_d   = (bus.e_mdu_op == 2'b01) ? MUL_LOAD : DIV_LOAD;
          state_d = MDU;
        end else if (load_use) begin
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          bubble_e  = 1'b1;
          lu_bubble = 1'b1;
        end
      end
    endcase
    if (reset) begin
      stall_f        = 1'b0;
      stall_d        = 1'b0;
      stall_e        = 1'b0;
      bubble_e       = 1'b0;
      flush_fd       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      mdu_done       = 1'b0;
      lu_bubble      = 1'b0;
    end
  end

  // Sequencer state, MDU counter and pending redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tgt_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.stall_f        = stall_f;
  assign bus.stall_d        = stall_d;
  assign bus.stall_e        = stall_e;
  assign bus.bubble_e       = bubble_e;
  assign bus.flush_fd       = flush_fd;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.mdu_done       = mdu_done;
  assign bus.state_o        = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_loaduse_q, perf_loaduse_d;
  logic [31:0] perf_redirect_q, perf_redirect_d;

  // Event counters wrap naturally at 2^32.
  always_comb begin
    perf_stall_d    = perf_stall_q + 32'(stall_e);
    perf_loaduse_d  = perf_loaduse_q + 32'(lu_bubble);
    perf_redirect_d = perf_redirect_q + 32'(redirect_valid);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q    <= 32'd0;
      perf_loaduse_q  <= 32'd0;
      perf_redirect_q <= 32'd0;
    end else begin
      perf_stall_q    <= perf_stall_d;
      perf_loaduse_q  <= perf_loaduse_d;
      perf_redirect_q <= perf_redirect_d;
    end
  end

  assign perf_stall    = perf_stall_q;
  assign perf_loaduse  = perf_loaduse_q;
  assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, hand-written multi-cycle
// sequences, and randomized stimulus against a behavioural model.
module tb_pipe_ctrl;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 65;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_loaduse, perf_redirect;
`endif

  pipe_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall    (perf_stall),
    .perf_loaduse  (perf_loaduse),
    .perf_redirect (perf_redirect)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected control vector bit order: {stall_f, stall_d, stall_e, bubble_e, flush_fd, redirect_valid, mdu_done}
  localparam logic [6:0] IDLE  = 7'b0000000;
  localparam logic [6:0] STALL = 7'b1110000;
  localparam logic [6:0] LU    = 7'b1101000;
  localparam logic [6:0] BR_RV = 7'b0001110;
  localparam logic [6:0] BR_NR = 7'b0001100;
  localparam logic [6:0] DONE  = 7'b0000001;
  localparam logic [6:0] SDONE = 7'b1110001;

  typedef struct {
    logic        dv;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, ev;
    logic [4:0]  dst;
    logic        ism, br;
    logic [63:0] tgt;
    logic [1:0]  op;
    logic        is, ms;
    logic [6:0]  exp;
    logic [63:0] epc;
    logic [1:0]  est;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic dv, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic ev, logic [4:0] dst, logic ism, logic br, logic [63:0] tgt,
                              logic [1:0] op, logic is, logic ms, logic [6:0] exp,
                              logic [63:0] epc, logic [1:0] est);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ev = ev; v.dst = dst;
    v.ism = ism; v.br = br; v.tgt = tgt; v.op = op; v.is = is; v.ms = ms;
    v.exp = exp; v.epc = epc; v.est = est;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.d_valid = v.dv; bus.d_rs1 = v.rs1; bus.d_rs2 = v.rs2;
    bus.d_use_rs1 = v.u1; bus.d_use_rs2 = v.u2;
    bus.e_valid = v.ev; bus.e_dst = v.dst; bus.e_ismem = v.ism; bus.e_branch = v.br;
    bus.e_target = v.tgt; bus.e_mdu_op = v.op; bus.i_stall = v.is; bus.m_stall = v.ms;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 2'b00, 0, 0, IDLE, 64'd0, 2'd0));
  endtask

  task automatic check(input string nm, input logic [6:0] exp, input logic [63:0] epc,
                       input logic [1:0] est);
    logic [6:0] act;
    act = {bus.stall_f, bus.stall_d, bus.stall_e, bus.bubble_e, bus.flush_fd,
           bus.redirect_valid, bus.mdu_done};
    n_cmp++;
    if (act !== exp || bus.state_o !== est || (exp[1] && bus.redirect_pc !== epc)) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b pc=%h st=%0d, want ctl=%b pc=%h st=%0d",
               nm, act, bus.redirect_pc, bus.state_o, exp, epc, est);
    end
  endtask

  // One clock: sample on the falling edge, then advance past the rising edge.
  task automatic cyc_check(input string nm, input logic [6:0] exp, input logic [63:0] epc,
                           input logic [1:0] est);
    @(negedge clk);
    check(nm, exp, epc, est);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Behavioural reference: cycles an MDU op still owes execute, and a pending redirect.
  int          m_left  = 0;
  bit          m_redir = 0;
  logic [63:0] m_pc    = 64'd0;

  task automatic model_eval(output logic [6:0] exp, output logic [63:0] epc, output logic [1:0] est);
    logic lu, s;
    lu = bus.d_valid && bus.e_valid && bus.e_ismem && bus.e_dst != 0 &&
         ((bus.d_use_rs1 && bus.d_rs1 == bus.e_dst) || (bus.d_use_rs2 && bus.d_rs2 == bus.e_dst));
    s   = bus.m_stall;
    exp = IDLE;
    epc = 64'd0;
    est = (m_left > 0) ? 2'd1 : (m_redir ? 2'd2 : 2'd0);
    if (reset) exp = IDLE;
    else if (m_left > 1) exp = STALL;
    else if (m_left == 1) exp = {s, s, s, 3'b000, 1'b1};
    else if (m_redir) begin
      exp = {s, s, s, 1'b1, 1'b1, !bus.i_stall, 1'b0};
      epc = m_pc;
    end else if (s) exp = STALL;
    else if (bus.e_valid && bus.e_branch) begin
      exp = bus.i_stall ? BR_NR : BR_RV;
      epc = bus.e_target;
    end else if (bus.e_valid && (bus.e_mdu_op == 1 || bus.e_mdu_op == 2)) exp = STALL;
    else if (lu) exp = LU;
  endtask

  task automatic model_step();
    if (reset) begin
      m_left = 0; m_redir = 0; m_pc = 64'd0;
    end else if (m_left > 1) m_left--;
    else if (m_left == 1) begin
      if (!bus.m_stall) m_left = 0;
    end else if (m_redir) begin
      if (!bus.i_stall) m_redir = 0;
    end else if (bus.m_stall) begin
    end else if (bus.e_valid && bus.e_branch) begin
      if (bus.i_stall) begin
        m_redir = 1; m_pc = bus.e_target;
      end
    end else if (bus.e_valid && (bus.e_mdu_op == 1 || bus.e_mdu_op == 2))
      m_left = ((bus.e_mdu_op == 1) ? MUL_LAT : DIV_LAT) - 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  e;
    logic [63:0] p;
    logic [1:0]  st;
    int          nst;
    bit          seen;

    tbl[0]  = mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 64'd0,          2'b00, 0, 0, LU,    64'd0,          2'd0);
    tbl[1]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 64'd0,          2'b00, 0, 0, IDLE,  64'd0,          2'd0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h80000040,   2'b00, 0, 0, BR_RV, 64'h80000040,   2'd0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h100,        2'b00, 1, 0, BR_NR, 64'd0,          2'd0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hdead,       2'b00, 1, 0, BR_NR, 64'd0,          2'd2);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'hbeef,       2'b00, 1, 0, BR_NR, 64'd0,          2'd2);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h5555,       2'b00, 0, 0, BR_RV, 64'h100,        2'd2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,          2'b00, 0, 0, IDLE,  64'd0,          2'd0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0,          2'b01, 0, 0, STALL, 64'd0,          2'd0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0,          2'b01, 0, 0, STALL, 64'd0,          2'd1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0,          2'b01, 0, 0, DONE,  64'd0,          2'd1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,          2'b00, 0, 0, IDLE,  64'd0,          2'd0);
    tbl[12] = mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 64'd0,          2'b00, 0, 1, STALL, 64'd0,          2'd0);
    tbl[13] = mk(1, 3, 7, 1, 1, 1, 7, 1, 0, 64'd0,          2'b00, 0, 0, LU,    64'd0,          2'd0);
    tbl[14] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 64'd0,          2'b00, 0, 0, IDLE,  64'd0,          2'd0);
    tbl[15] = mk(1, 9, 0, 0, 0, 1, 9, 1, 0, 64'd0,          2'b00, 0, 0, IDLE,  64'd0,          2'd0);

    do_reset();
    cyc_check("reset_idle", IDLE, 64'd0, 2'd0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      cyc_check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].epc, tbl[i].est);
    end

    // DIV with m_stall raised when one count remains, held 4 cycles.
    do_reset();
    drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0, 2'b10, 0, 0, IDLE, 64'd0, 2'd0));
    cyc_check("div_accept", STALL, 64'd0, 2'd0);
    for (int i = 1; i <= 62; i++) cyc_check($sformatf("div_busy%0d", i), STALL, 64'd0, 2'd1);
    bus.m_stall = 1'b1;
    cyc_check("div_cnt1_mstall", STALL, 64'd0, 2'd1);
    for (int i = 0; i < 3; i++) cyc_check($sformatf("div_done_mstall%0d", i), SDONE, 64'd0, 2'd1);
    bus.m_stall = 1'b0;
    cyc_check("div_done", DONE, 64'd0, 2'd1);
    drive_idle();
    cyc_check("div_after", IDLE, 64'd0, 2'd0);

    // Plain DIV: count stall_e cycles until done, bounded.
    drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0, 2'b10, 0, 0, IDLE, 64'd0, 2'd0));
    nst  = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.mdu_done) seen = 1;
      else if (bus.stall_e) nst++;
      @(posedge clk);
      #1;
    end
    drive_idle();
    n_cmp++;
    if (!seen || nst != DIV_LAT - 1) begin
      n_fail++;
      $display("FAIL div_stall_count: got %0d (done=%0d), want %0d (done=1)", nst, seen, DIV_LAT - 1);
    end
    cyc_check("div2_after", IDLE, 64'd0, 2'd0);

    // Reset asserted while a DIV is in flight.
    drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0, 2'b10, 0, 0, IDLE, 64'd0, 2'd0));
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc_check("reset_mid_mdu", IDLE, 64'd0, 2'd1);
    reset = 1'b0;
    drive_idle();
    cyc_check("after_reset_mdu", IDLE, 64'd0, 2'd0);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset         = (i == 0) || ($urandom_range(0, 99) == 0);
      bus.d_valid   = ($urandom_range(0, 3) != 0);
      bus.d_rs1     = 5'($urandom_range(0, 7));
      bus.d_rs2     = 5'($urandom_range(0, 7));
      bus.d_use_rs1 = 1'($urandom_range(0, 1));
      bus.d_use_rs2 = 1'($urandom_range(0, 1));
      bus.e_valid   = ($urandom_range(0, 4) != 0);
      bus.e_dst     = 5'($urandom_range(0, 7));
      bus.e_ismem   = 1'($urandom_range(0, 1));
      bus.e_branch  = ($urandom_range(0, 7) == 0);
      bus.e_target  = {$urandom, $urandom};
      r = $urandom_range(0, 99);
      bus.e_mdu_op  = (r < 8) ? 2'b01 : (r < 11) ? 2'b10 : (r < 13) ? 2'b11 : 2'b00;
      bus.i_stall   = ($urandom_range(0, 2) == 0);
      bus.m_stall   = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      model_eval(e, p, st);
      check($sformatf("rand%0d", i), e, p, st);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
